// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock setting controller.
//   - state_t      : controller FSM states
//   - char indices : display character positions (bit positions in blank_mask)
//   - digit widths and maxima for the BCD time fields
//   - bcd_time_t   : packed BCD time with increment helpers
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  // Character positions on the display, left to right.
  localparam int unsigned HRS_D     = 0;
  localparam int unsigned HRS_U     = 1;
  localparam int unsigned COLON_HM  = 2;
  localparam int unsigned MIN_D     = 3;
  localparam int unsigned MIN_U     = 4;
  localparam int unsigned COLON_MS  = 5;
  localparam int unsigned SEC_D     = 6;
  localparam int unsigned SEC_U     = 7;
  localparam int unsigned NUM_CHARS = 8;

  // Digit widths.
  localparam int unsigned HRS_D_W = 2;
  localparam int unsigned HRS_U_W = 4;
  localparam int unsigned MIN_D_W = 3;
  localparam int unsigned MIN_U_W = 4;
  localparam int unsigned SEC_D_W = 3;
  localparam int unsigned SEC_U_W = 4;

  // Digit maxima.
  localparam int unsigned UNITS_MAX      = 9;
  localparam int unsigned TENS_MAX       = 5;
  localparam int unsigned HRS_D_MAX      = 2;
  localparam int unsigned HRS_U_MAX_LATE = 3;  // units limit once hrs_d is 2

  typedef struct packed {
    logic [HRS_D_W-1:0] hrs_d;
    logic [HRS_U_W-1:0] hrs_u;
    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
  } bcd_time_t;

  // Hours 00..23, wrapping 23 -> 00.
  function automatic bcd_time_t hrs_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hrs_d == HRS_D_W'(HRS_D_MAX) && t.hrs_u == HRS_U_W'(HRS_U_MAX_LATE)) begin
      r.hrs_d = '0;
      r.hrs_u = '0;
    end else if (t.hrs_u == HRS_U_W'(UNITS_MAX)) begin
      r.hrs_d = t.hrs_d + 1'b1;
      r.hrs_u = '0;
    end else begin
      r.hrs_u = t.hrs_u + 1'b1;
    end
    return r;
  endfunction

  // Minutes 00..59, wrapping 59 -> 00 with no carry into hours.
  function automatic bcd_time_t min_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_u == MIN_U_W'(UNITS_MAX)) begin
      r.min_u = '0;
      if (t.min_d == MIN_D_W'(TENS_MAX)) r.min_d = '0;
      else                               r.min_d = t.min_d + 1'b1;
    end else begin
      r.min_u = t.min_u + 1'b1;
    end
    return r;
  endfunction

  // One second of running time with full carry chain, 23:59:59 -> 00:00:00.
  function automatic bcd_time_t sec_tick_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_u != SEC_U_W'(UNITS_MAX)) begin
      r.sec_u = t.sec_u + 1'b1;
    end else begin
      r.sec_u = '0;
      if (t.sec_d != SEC_D_W'(TENS_MAX)) begin
        r.sec_d = t.sec_d + 1'b1;
      end else begin
        r.sec_d = '0;
        r = min_inc(r);
        if (t.min_d == MIN_D_W'(TENS_MAX) && t.min_u == MIN_U_W'(UNITS_MAX))
          r = hrs_inc(r);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, level debouncer and press pulse for one
// raw push button.
//   px_clk  : clock
//   reset   : synchronous, active-high reset
//   btn     : raw asynchronous button level, high = pressed
//   press   : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 315000
) (
  input  logic px_clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter runs only while the synchronised input disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: BCD time-of-day counter with two-button setting.
//   px_clk      : pixel clock, rising edge
//   reset       : synchronous, active-high reset
//   sec_tick    : 1 Hz one-cycle pulse
//   frame_start : one-cycle pulse per video frame (blink timebase)
//   btn_mode    : raw mode button (RUN -> SET_HRS -> SET_MIN -> RUN)
//   btn_inc     : raw increment button (active in set states)
//   hrs_d..sec_u: registered BCD time digits
//   blank_mask  : per-character blank, bit 0 = hrs_d ... bit 7 = sec_u
//   set_active  : high while in SET_HRS or SET_MIN
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 315000,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       frame_start,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [2:0] min_d,
  output logic [3:0] min_u,
  output logic [2:0] sec_d,
  output logic [3:0] sec_u,
  output logic [7:0] blank_mask,
  output logic       set_active
);

  import clock_pkg::*;

  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic mode_press;
  logic inc_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .px_clk (px_clk),
    .reset  (reset),
    .btn    (btn_mode),
    .press  (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .px_clk (px_clk),
    .reset  (reset),
    .btn    (btn_inc),
    .press  (inc_press)
  );

  state_t          state_q, state_d;
  bcd_time_t       time_q, time_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [7:0]      mask_d;

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    mask_d      = '0;

    // Mode press has priority over a coincident tick or inc press.
    unique case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d      = SET_HRS;
          time_d.sec_d = '0;
          time_d.sec_u = '0;
        end else if (sec_tick) begin
          time_d = sec_tick_inc(time_q);
        end
      end
      SET_HRS: begin
        if (mode_press)     state_d = SET_MIN;
        else if (inc_press) time_d  = hrs_inc(time_q);
      end
      SET_MIN: begin
        if (mode_press)     state_d = RUN;
        else if (inc_press) time_d  = min_inc(time_q);
      end
      default: state_d = RUN;
    endcase

    // Any edit or state change restarts the blink with digits visible.
    if (state_d != state_q || inc_press) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (state_q != RUN && frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Mask is built from next-state values so it lines up with the state.
    if (state_d == SET_HRS) begin
      mask_d[HRS_D] = phase_d;
      mask_d[HRS_U] = phase_d;
    end else if (state_d == SET_MIN) begin
      mask_d[MIN_D] = phase_d;
      mask_d[MIN_U] = phase_d;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q     <= RUN;
      time_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_mask  <= '0;
      set_active  <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_mask  <= mask_d;
      set_active  <= (state_d != RUN);
    end
  end

  assign hrs_d = time_q.hrs_d;
  assign hrs_u = time_q.hrs_u;
  assign min_d = time_q.min_d;
  assign min_u = time_q.min_u;
  assign sec_d = time_q.sec_d;
  assign sec_u = time_q.sec_u;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl with
// DEBOUNCE_CYCLES=4 and BLINK_FRAMES=2. Time is compared as a packed hex
// value, e.g. 32'h00235959 for 23:59:59.
module tb_clock_set_ctrl;

  logic       px_clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic       frame_start;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] hrs_d;
  logic [3:0] hrs_u;
  logic [2:0] min_d;
  logic [3:0] min_u;
  logic [2:0] sec_d;
  logic [3:0] sec_u;
  logic [7:0] blank_mask;
  logic       set_active;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_FRAMES    (2)
  ) dut (
    .px_clk      (px_clk),
    .reset       (reset),
    .sec_tick    (sec_tick),
    .frame_start (frame_start),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .hrs_d       (hrs_d),
    .hrs_u       (hrs_u),
    .min_d       (min_d),
    .min_u       (min_u),
    .sec_d       (sec_d),
    .sec_u       (sec_u),
    .blank_mask  (blank_mask),
    .set_active  (set_active)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_time();
    return {8'h00, 2'b00, hrs_d, hrs_u, 1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
  endfunction

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge px_clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(10);
    btn_mode = 1'b0;
    step(10);
  endtask

  task automatic press_inc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step(10);
      btn_inc = 1'b0;
      step(10);
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step(1);
      sec_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    sec_tick    = 1'b0;
    frame_start = 1'b0;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    check("reset_time", cur_time(), 32'h00000000);
    check("reset_mask", {24'h0, blank_mask}, 32'h00);
    check("reset_set",  {31'h0, set_active}, 32'h0);

    // Inc ignored in RUN.
    press_inc(1);
    check("run_inc_ignored", cur_time(), 32'h00000000);

    // Enter SET_HRS.
    press_mode();
    check("sethrs_active", {31'h0, set_active}, 32'h1);
    check("sethrs_mask0",  {24'h0, blank_mask}, 32'h00);

    // Ticks ignored while setting.
    ticks(3);
    check("sethrs_tick_ignored", cur_time(), 32'h00000000);

    // Blink: toggles every 2 frames.
    frames(1);
    check("blink_f1", {24'h0, blank_mask}, 32'h00);
    frames(1);
    check("blink_f2", {24'h0, blank_mask}, 32'h03);
    frames(1);
    check("blink_f3", {24'h0, blank_mask}, 32'h03);
    frames(1);
    check("blink_f4", {24'h0, blank_mask}, 32'h00);
    frames(2);
    check("blink_f6", {24'h0, blank_mask}, 32'h03);
    press_inc(1);
    check("blink_inc_clear", {24'h0, blank_mask}, 32'h00);
    check("hrs_01",          cur_time(), 32'h00010000);

    // Short glitch on inc: no press. Long hold: exactly one press.
    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(10);
    check("inc_glitch", cur_time(), 32'h00010000);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(10);
    check("inc_hold", cur_time(), 32'h00020000);

    press_inc(21);
    check("hrs_23", cur_time(), 32'h00230000);
    press_inc(1);
    check("hrs_wrap", cur_time(), 32'h00000000);
    press_inc(23);

    // SET_MIN.
    press_mode();
    check("setmin_active", {31'h0, set_active}, 32'h1);
    check("setmin_mask0",  {24'h0, blank_mask}, 32'h00);
    frames(2);
    check("setmin_blink", {24'h0, blank_mask}, 32'h18);
    press_inc(59);
    check("min_59", cur_time(), 32'h00235900);
    press_inc(1);
    check("min_wrap_nocarry", cur_time(), 32'h00230000);
    press_inc(59);

    // Back to RUN and roll over.
    press_mode();
    check("run_active", {31'h0, set_active}, 32'h0);
    check("run_mask",   {24'h0, blank_mask}, 32'h00);
    check("run_2359",   cur_time(), 32'h00235900);
    ticks(59);
    check("tick_235959", cur_time(), 32'h00235959);
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    check("tick_rollover", cur_time(), 32'h00000000);
    step(1);

    // 07:59 then inc minutes: no carry into hours.
    press_mode();
    press_inc(7);
    press_mode();
    press_inc(59);
    check("min59_hrs07", cur_time(), 32'h00075900);
    press_inc(1);
    check("min00_hrs07", cur_time(), 32'h00070000);

    // Build 12:34:56.
    press_mode();               // RUN
    press_mode();               // SET_HRS
    press_inc(5);
    press_mode();               // SET_MIN
    press_inc(34);
    press_mode();               // RUN
    ticks(56);
    check("time_123456", cur_time(), 32'h00123456);

    // Mode press coinciding with sec_tick: press pulse is visible after the
    // 6th edge of a held button and is consumed on the 7th.
    btn_mode = 1'b1;
    step(6);
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    check("coincide_time", cur_time(), 32'h00123400);
    check("coincide_set",  {31'h0, set_active}, 32'h1);
    step(3);
    btn_mode = 1'b0;
    step(10);

    // Reset while in SET_MIN with the mask showing blank.
    press_mode();
    frames(2);
    check("pre_reset_mask", {24'h0, blank_mask}, 32'h18);
    reset = 1'b1;
    step(1);
    check("midset_reset_time", cur_time(), 32'h00000000);
    check("midset_reset_mask", {24'h0, blank_mask}, 32'h00);
    check("midset_reset_set",  {31'h0, set_active}, 32'h0);
    reset = 1'b0;
    step(1);

    // After reset the FSM is in RUN: ticks count, one mode press enters SET_HRS.
    ticks(1);
    check("post_reset_tick", cur_time(), 32'h00000001);
    press_mode();
    check("post_reset_sethrs", {31'h0, set_active}, 32'h1);
    check("post_reset_secclr", cur_time(), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
